// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_ctrl                                                     |
// | Brief    : UART receive frame controller (start/data/parity/stop checking)  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       RX_IN,
  input  logic [4:0] Prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       Sampled_bit,
  output logic       S_EN,
  output logic [4:0] edge_count,
  output logic       edge_end,
  output logic [7:0] P_DATA,
  output logic       Data_valid,
  output logic       Parity_error,
  output logic       Stop_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t     r_state, w_state_next;
  state_t     r_chk_kind;
  logic [4:0] r_ps;
  logic       r_par_en;
  logic       r_par_typ;
  logic [4:0] r_edge_cnt, w_edge_cnt_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic       r_chk;
  logic [7:0] r_shift;
  logic       r_par_flag;
  logic       w_busy;
  logic       w_edge_end;
  logic       w_start_det;
  logic       w_false_start;
  logic       w_chk_stop;
  logic       w_par_err;

  assign w_busy        = (r_state == START) || (r_state == DATA) ||
                         (r_state == PARITY) || (r_state == STOP);
  assign w_edge_end    = w_busy && (r_edge_cnt == (r_ps - 5'd1));
  assign w_start_det   = (r_state == IDLE) && !RX_IN;
  // The sampler's vote arrives one cycle after edge_end, hence the chk tag.
  assign w_false_start = r_chk && (r_chk_kind == START) && Sampled_bit;
  assign w_chk_stop    = r_chk && (r_chk_kind == STOP);
  assign w_par_err     = r_par_flag && r_par_en;

  assign S_EN       = (r_state != IDLE);
  assign edge_count = r_edge_cnt;
  assign edge_end   = w_edge_end;

  always_comb begin
    w_state_next    = r_state;
    w_edge_cnt_next = 5'd0;
    w_bit_cnt_next  = r_bit_cnt;
    if (w_busy && !w_edge_end) begin
      w_edge_cnt_next = r_edge_cnt + 5'd1;
    end
    case (r_state)
      IDLE: begin
        w_bit_cnt_next = 3'd0;
        if (!RX_IN) w_state_next = START;
      end
      START: begin
        if (w_edge_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_edge_end) begin
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_next = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_edge_end) w_state_next = STOP;
      end
      STOP: begin
        if (w_edge_end) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_false_start) begin
      w_state_next    = IDLE;
      w_edge_cnt_next = 5'd0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_edge_cnt <= 5'd0;
      r_bit_cnt  <= 3'd0;
      r_ps       <= 5'd0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_chk      <= 1'b0;
      r_chk_kind <= IDLE;
    end else begin
      r_state    <= w_state_next;
      r_edge_cnt <= w_edge_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_chk      <= w_edge_end;
      r_chk_kind <= r_state;
      // Frame configuration is frozen at start detect.
      if (w_start_det) begin
        r_ps      <= Prescale;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_shift      <= 8'h00;
      r_par_flag   <= 1'b0;
      P_DATA       <= 8'h00;
      Data_valid   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
    end else begin
      Data_valid   <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
      if (r_chk && (r_chk_kind == DATA)) begin
        r_shift <= {Sampled_bit, r_shift[7:1]};
      end
      if (r_chk && (r_chk_kind == PARITY)) begin
        r_par_flag <= ((^r_shift) ^ r_par_typ) != Sampled_bit;
      end
      if (w_chk_stop) begin
        Parity_error <= w_par_err;
        Stop_error   <= !Sampled_bit;
        Data_valid   <= !w_par_err && Sampled_bit;
        if (!w_par_err && Sampled_bit) P_DATA <= r_shift;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// Testbench for uart_rx_ctrl: directed frames with literal expectations plus
// randomized frames checked every cycle against a frame-level timing model.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       RX_IN = 1'b1;
  logic [4:0] Prescale = 5'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       Sampled_bit = 1'b1;
  logic       S_EN;
  logic [4:0] edge_count;
  logic       edge_end;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       Parity_error;
  logic       Stop_error;

  uart_rx_ctrl dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Sampled_bit  (Sampled_bit),
    .S_EN         (S_EN),
    .edge_count   (edge_count),
    .edge_end     (edge_end),
    .P_DATA       (P_DATA),
    .Data_valid   (Data_valid),
    .Parity_error (Parity_error),
    .Stop_error   (Stop_error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Ideal external sampler: mid-bit sample, presented the cycle after edge_end.
  int   smp_ps = 8;
  logic mid = 1'b1;
  always @(posedge CLK) begin
    if (S_EN && (int'(edge_count) == smp_ps / 2)) mid <= RX_IN;
    if (edge_end) Sampled_bit <= mid;
  end

  // Frame-level reference model.
  int          m_t0 = -1000;
  int          m_ps = 8;
  int          m_n = 0;
  bit          m_false = 1'b0;
  bit          m_active = 1'b0;
  logic [10:0] exp_pulse [int];
  logic [7:0]  exp_pdata = 8'h00;
  int          last_dv = -1;
  int          last_pe = -1;
  int          last_se = -1;

  int          d, last;
  logic        e_sen, e_ee, e_dv, e_pe, e_se;
  logic [4:0]  e_ec;
  logic [10:0] p;

  always @(posedge CLK) begin
    #1;
    d = cyc - m_t0;
    e_sen = 1'b0; e_ec = 5'd0; e_ee = 1'b0;
    e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0;
    if (m_active) begin
      last = m_false ? m_ps + 1 : m_n;
      if (d >= 1 && d <= last) begin
        e_sen = 1'b1;
        e_ec  = 5'((d - 1) % m_ps);
        e_ee  = (int'(e_ec) == m_ps - 1);
      end else if (!m_false && d == m_n + 1) begin
        e_sen = 1'b1;
      end
    end
    if (exp_pulse.exists(cyc)) begin
      p = exp_pulse[cyc];
      exp_pulse.delete(cyc);
      e_dv = p[10]; e_pe = p[9]; e_se = p[8];
      if (e_dv) exp_pdata = p[7:0];
    end
    check("S_EN", S_EN, e_sen);
    check("edge_count", edge_count, e_ec);
    check("edge_end", edge_end, e_ee);
    check("Data_valid", Data_valid, e_dv);
    check("Parity_error", Parity_error, e_pe);
    check("Stop_error", Stop_error, e_se);
    check("P_DATA", P_DATA, exp_pdata);
    if (Data_valid) last_dv = cyc;
    if (Parity_error) last_pe = cyc;
    if (Stop_error) last_se = cyc;
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    #2 Reset = 1'b0;
    m_active = 1'b0;
    exp_pulse.delete();
    exp_pdata = 8'h00;
    RX_IN = 1'b1;
    #1;
    check("rst_S_EN", S_EN, 1'b0);
    check("rst_edge_count", edge_count, 5'd0);
    check("rst_Data_valid", Data_valid, 1'b0);
    check("rst_P_DATA", P_DATA, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  // Called at a negedge; that cycle is T0 (start bit first seen in IDLE).
  task automatic send_frame(input int ps, input logic [7:0] b, input bit pe, input bit pt,
                            input bit pbit, input bit stop, input bit done_low,
                            input int abort_j, input int chg_j);
    logic bitv [0:10];
    int   nb, n;
    bit   perr;
    bitv[0] = 1'b0;
    for (int i = 0; i < 8; i++) bitv[i + 1] = b[i];
    bitv[9]  = pe ? pbit : stop;
    bitv[10] = stop;
    nb = 10 + int'(pe);
    n  = nb * ps;
    Prescale = 5'(ps); PAR_EN = pe; PAR_TYP = pt; smp_ps = ps;
    m_t0 = cyc; m_ps = ps; m_n = n; m_false = 1'b0; m_active = 1'b1;
    perr = pe && (pbit != ((^b) ^ pt));
    exp_pulse[cyc + n + 2] = {!perr && stop, perr, !stop, b};
    for (int j = 0; j < n + 2; j++) begin
      if (j == abort_j) begin
        do_reset();
        return;
      end
      if (j == chg_j) begin
        Prescale = 5'd16; PAR_EN = !pe; PAR_TYP = !pt;
      end
      RX_IN = (j < n) ? bitv[j / ps] : !(done_low && j == n + 1);
      @(negedge CLK);
    end
    Prescale = 5'(ps); PAR_EN = pe; PAR_TYP = pt;
  endtask

  task automatic false_start(input int ps);
    Prescale = 5'(ps); smp_ps = ps;
    m_t0 = cyc; m_ps = ps; m_false = 1'b1; m_active = 1'b1;
    for (int j = 0; j < ps + 2; j++) begin
      RX_IN = (j < 2) ? 1'b0 : 1'b1;
      @(negedge CLK);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int       t0, prev_dv, r_ps, r_gap;
  logic [7:0] r_b;
  bit       r_pe, r_pt, r_pbit, r_stop, r_dl;

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_P_DATA", P_DATA, 8'h00);
    check("reset_S_EN", S_EN, 1'b0);
    Reset = 1'b1;
    idle(2);

    // 8N1 good frame
    t0 = cyc;
    send_frame(8, 8'hA5, 0, 0, 0, 1, 0, -1, -1);
    check("a5_latency", last_dv - t0, 82);
    check("a5_data", P_DATA, 8'hA5);
    idle(3);

    // Even parity, wrong parity bit: error pulse, data held
    prev_dv = last_dv;
    t0 = cyc;
    send_frame(16, 8'h07, 1, 0, 0, 1, 0, -1, -1);
    check("perr_latency", last_pe - t0, 178);
    check("perr_no_dv", last_dv, prev_dv);
    check("perr_data_held", P_DATA, 8'hA5);
    idle(2);

    t0 = cyc;
    send_frame(16, 8'h07, 1, 0, 1, 1, 0, -1, -1);
    check("par_ok_latency", last_dv - t0, 178);
    check("par_ok_data", P_DATA, 8'h07);

    // Bad stop bit, start held low through DONE, then back-to-back good frame
    prev_dv = last_dv;
    t0 = cyc;
    send_frame(8, 8'h5A, 0, 0, 0, 0, 1, -1, -1);
    check("serr_latency", last_se - t0, 82);
    check("serr_no_dv", last_dv, prev_dv);
    t0 = cyc;
    send_frame(8, 8'hC3, 0, 0, 0, 1, 0, -1, -1);
    check("b2b_latency", last_dv - t0, 82);
    check("b2b_data", P_DATA, 8'hC3);
    idle(2);

    // False start then a real frame
    prev_dv = last_dv;
    t0 = cyc;
    false_start(8);
    check("fs_idle", S_EN, 1'b0);
    check("fs_no_dv", last_dv, prev_dv);
    send_frame(8, 8'h81, 0, 0, 0, 1, 0, -1, -1);
    check("fs_next_data", P_DATA, 8'h81);
    idle(2);

    // Reset during data bit 4, then a full frame
    send_frame(8, 8'hFF, 0, 0, 0, 1, 0, 5 * 8 + 2, -1);
    check("abort_P_DATA", P_DATA, 8'h00);
    idle(1);
    send_frame(8, 8'h3C, 0, 0, 0, 1, 0, -1, -1);
    check("post_rst_data", P_DATA, 8'h3C);
    idle(2);

    // Configuration inputs change mid-frame
    t0 = cyc;
    send_frame(8, 8'h66, 0, 0, 0, 1, 0, -1, 3 * 8);
    check("cfg_chg_latency", last_dv - t0, 82);
    check("cfg_chg_data", P_DATA, 8'h66);
    idle(2);

    for (int k = 0; k < 30; k++) begin
      r_ps   = int'($urandom_range(31, 4));
      r_b    = 8'($urandom);
      r_pe   = 1'($urandom_range(1, 0));
      r_pt   = 1'($urandom_range(1, 0));
      r_pbit = 1'($urandom_range(1, 0));
      r_stop = ($urandom_range(3, 0) != 0);
      r_gap  = int'($urandom_range(3, 0));
      r_dl   = (r_gap == 0) && ($urandom_range(1, 0) == 1);
      if ($urandom_range(7, 0) == 0) false_start(r_ps);
      send_frame(r_ps, r_b, r_pe, r_pt, r_pbit, r_stop, r_dl, -1, -1);
      if (!r_dl) idle(r_gap);
    end
    idle(5);
    check("no_pending_pulses", exp_pulse.num(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
- CLK  in  1  receiver oversampling clock
- Reset  in  1  asynchronous, active-low
- RX_IN  in  1  serial line; idles high
- Prescale  in  5  oversampling ratio; legal values 4..31
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- Sampled_bit  in  1  majority-voted bit from the data sampler
- S_EN  out  1  sampler enable
- edge_count  out  5  oversample index within the current bit
- edge_end  out  1  last oversample of the current bit
- P_DATA  out  8  received byte
- Data_valid  out  1  one-cycle pulse for a good frame
- Parity_error  out  1  one-cycle pulse for a parity mismatch
- Stop_error  out  1  one-cycle pulse for a bad stop bit

REQ-002 Reset SHALL be asynchronous and active-low; CLK SHALL be the clock. All state SHALL be on the CLK rising edge.

Function
REQ-003 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and DONE.
REQ-004 IDLE: when RX_IN==0 is sampled, the block SHALL latch Prescale into an internal register (Ps) and go to START on the next cycle. Otherwise it SHALL stay in IDLE.
REQ-005 In START, DATA, PARITY and STOP, edge_count SHALL increment by 1 each cycle. It SHALL count 0..Ps-1 and then wrap to 0.
REQ-006 edge_end SHALL be combinational: 1 iff state is START/DATA/PARITY/STOP and edge_count==Ps-1. It SHALL be 0 in every other case.
REQ-007 On edge_end, state transitions SHALL be:
- START -> DATA
- DATA -> DATA while fewer than 8 data bits have completed
- DATA -> PARITY after bit 7 if PAR_EN=1, otherwise -> STOP
- PARITY -> STOP
- STOP -> DONE
REQ-008 DONE SHALL last exactly one cycle, with edge_count held at 0, and then go to IDLE.
REQ-009 In IDLE, edge_count SHALL be 0.
REQ-010 S_EN SHALL be 1 in START, DATA, PARITY, STOP and DONE, and 0 in IDLE.
REQ-011 Sampled_bit is valid one cycle after edge_end. An internal check pulse (chk) SHALL be edge_end delayed by one cycle, tagged with the kind of bit that just completed.
REQ-012 When chk is tagged START and Sampled_bit==1 (false start), the block SHALL go to IDLE on the next cycle. edge_count SHALL be 0 and no output pulse SHALL be produced.
REQ-013 When chk is tagged DATA, Sampled_bit SHALL be shifted into an internal shift register, LSB first.
REQ-014 When chk is tagged PARITY, the block SHALL latch a parity-error flag. For even parity the flag is XOR(data bits) != Sampled_bit; for odd parity it is the inverse of that XOR compared with Sampled_bit.
REQ-015 When chk is tagged STOP (the DONE cycle), Stop_error_next SHALL equal ~Sampled_bit.
REQ-016 Data_valid, Parity_error and Stop_error SHALL be registered and pulse high for exactly 1 cycle, the cycle after DONE.
- Parity_error = latched flag AND PAR_EN.
- Data_valid = ~Parity_error AND ~Stop_error.
REQ-017 P_DATA SHALL take the shift register value only in the cycle Data_valid is asserted. It SHALL hold that value otherwise, including across errored frames.
REQ-018 A new start SHALL NOT be accepted during DONE. It SHALL be accepted in IDLE from the cycle of the output pulses onward.
REQ-019 Changes on Prescale, PAR_EN or PAR_TYP mid-frame SHALL NOT affect the current frame. PAR_EN and PAR_TYP SHALL be latched at start detect, like Prescale. Prescale is also used directly by the sampler, so it shall be held static during a frame.
REQ-020 Frame latency: start detect at cycle T0 gives the output pulse at T0 + Ps*(10+PAR_EN) + 2.

Reset
REQ-021 While Reset==0, the block SHALL be in IDLE with: edge_count=0, S_EN=0, edge_end=0, P_DATA=8'h00, Data_valid=0, Parity_error=0, Stop_error=0, shift register=0, parity flag=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no output pulse. After release, the next falling RX_IN SHALL start a fresh frame.

Verification
REQ-023 Prescale=8, PAR_EN=0, byte 8'hA5, stop=1, ideal sampler model -> Data_valid for 1 cycle at T0+82, P_DATA=8'hA5, no error pulses.
REQ-024 Prescale=16, PAR_EN=1, PAR_TYP=0, byte 8'h07, parity bit=1 -> Data_valid at T0+178, P_DATA=8'h07. The same frame with parity bit=0 -> Parity_error pulse, Data_valid=0, P_DATA unchanged.
REQ-025 Prescale=8, stop bit driven 0 -> Stop_error pulse, Data_valid=0. A back-to-back correct frame started immediately after -> received correctly.
REQ-026 RX_IN low for 2 cycles then high (false start), Prescale=8 -> chk at T0+9 sees 1, IDLE by T0+10, no pulses. The next real frame is received correctly.
REQ-027 Reset pulsed low during bit 4 of a frame -> all outputs at reset values immediately. The following full frame 8'h3C -> Data_valid with P_DATA=8'h3C.
REQ-028 Prescale changed from 8 to 16 during DATA -> frame timing stays at 8 per bit. edge_end asserts every 8 cycles until DONE.
